alu_operand_stage: RTL and testbench

- Registered, parametrised successor to the combinational ALU-source selector.
- Selects the ALU operand pair from register-file data, the accumulator buffer, or instruction immediate fields.
- Applies writeback forwarding to register-sourced operands, then queues the result in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between decode/register-read and the ALU, so the datapath can stall without losing operands.

---
 rtl/alu_operand_stage.sv | 75 +++++++
 tb/tb_alu_operand_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: forwarded ALU operand select feeding a 2-entry valid/ready skid buffer
module alu_operand_stage #(
  parameter int DATA_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int REG_AW   = 3,
  parameter int OFFS_LSB = 8,
  parameter int OFFS_W   = 5,
  parameter int SHAMT_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_src,
  input  logic [INSTR_W-1:0] instr,
  input  logic [REG_AW-1:0]  rs1_addr,
  input  logic [REG_AW-1:0]  rs2_addr,
  input  logic [DATA_W-1:0]  read_data1,
  input  logic [DATA_W-1:0]  read_data2,
  input  logic [DATA_W-1:0]  read_data_accbuf,
  input  logic               fwd_valid,
  input  logic [REG_AW-1:0]  fwd_addr,
  input  logic [DATA_W-1:0]  fwd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_input1,
  output logic [DATA_W-1:0]  alu_input2,
  output logic [1:0]         out_src
);
  logic [1:0]        count;
  logic [DATA_W-1:0] r1, r2, new_a, new_b, skid_a, skid_b;
  logic [1:0]        skid_src;
  logic              accept, consume;
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign accept = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  always_comb begin
    r1 = (fwd_valid && fwd_addr == rs1_addr) ? fwd_data : read_data1;
    r2 = (fwd_valid && fwd_addr == rs2_addr) ? fwd_data : read_data2;
    new_a = alu_src == 2'b01 ? read_data_accbuf : alu_src == 2'b11 ? r2 : r1;
    new_b = alu_src == 2'b00 ? r2 :
            alu_src == 2'b01 ? DATA_W'(instr[SHAMT_W-1:0]) :
            alu_src == 2'b10 ? instr[INSTR_W-1 -: DATA_W] :
            DATA_W'($signed(instr[OFFS_LSB+OFFS_W-1:OFFS_LSB]));
  end
  // head refills from skid when full, otherwise from the new request when empty or draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      out_src    <= '0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_src   <= '0;
    end else begin
      if (consume && count == 2'd2) begin
        alu_input1 <= skid_a;
        alu_input2 <= skid_b;
        out_src    <= skid_src;
      end else if (accept && (count == 2'd0 || consume)) begin
        alu_input1 <= new_a;
        alu_input2 <= new_b;
        out_src    <= alu_src;
      end
      if (accept && count == 2'd1 && !consume) begin
        skid_a   <= new_a;
        skid_b   <= new_b;
        skid_src <= alu_src;
      end
      count <= count + 2'(accept) - 2'(consume);
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: queue-based operand model checked every cycle plus directed literal checks
module tb_alu_operand_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, fwd_valid = 0;
  logic [1:0] alu_src = 0, out_src;
  logic [15:0] instr = 0;
  logic [2:0] rs1_addr = 0, rs2_addr = 0, fwd_addr = 0;
  logic [7:0] read_data1 = 0, read_data2 = 0, read_data_accbuf = 0, fwd_data = 0;
  logic [7:0] alu_input1, alu_input2;
  int checks = 0, errors = 0;
  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [1:0] src; } entry_t;
  entry_t q[$];

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_src(alu_src),
    .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .read_data1(read_data1),
    .read_data2(read_data2), .read_data_accbuf(read_data_accbuf), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .out_src(out_src));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t model();
    int r1, r2, offs, a, b;
    r1 = (fwd_valid && fwd_addr == rs1_addr) ? int'(fwd_data) : int'(read_data1);
    r2 = (fwd_valid && fwd_addr == rs2_addr) ? int'(fwd_data) : int'(read_data2);
    offs = int'(instr[12:8]);
    if (offs >= 16) offs = offs - 32;
    case (alu_src)
      2'd0: begin a = r1; b = r2; end
      2'd1: begin a = int'(read_data_accbuf); b = int'(instr[2:0]); end
      2'd2: begin a = r1; b = int'(instr[15:8]); end
      default: begin a = r2; b = (offs + 256) % 256; end
    endcase
    model = '{a: 8'(a), b: 8'(b), src: alu_src};
  endfunction

  always @(posedge clk or posedge rst) begin
    bit acc, con;
    if (rst) q.delete();
    else begin
      acc = in_valid && q.size() < 2;
      con = q.size() > 0 && out_ready;
      if (con) void'(q.pop_front());
      if (acc) q.push_back(model());
    end
  end

  always @(negedge clk) begin
    chk("m_valid", int'(out_valid), int'(q.size() > 0));
    chk("m_ready", int'(in_ready), int'(q.size() < 2));
    if (q.size() > 0 && out_valid) begin
      chk("m_a", int'(alu_input1), int'(q[0].a));
      chk("m_b", int'(alu_input2), int'(q[0].b));
      chk("m_src", int'(out_src), int'(q[0].src));
    end
  end

  task automatic set_req(input logic [1:0] s, input logic [15:0] ins, input logic [2:0] a1,
                         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] ac,
                         input logic fv, input logic [2:0] fa, input logic [7:0] fd);
    in_valid = 1; alu_src = s; instr = ins; rs1_addr = a1; rs2_addr = 3'd2;
    read_data1 = d1; read_data2 = d2; read_data_accbuf = ac;
    fwd_valid = fv; fwd_addr = fa; fwd_data = fd;
  endtask

  task automatic one(input logic [1:0] s, input logic [15:0] ins, input logic [2:0] a1,
                     input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] ac,
                     input logic fv, input logic [2:0] fa, input logic [7:0] fd,
                     input string name, input int ea, input int eb);
    set_req(s, ins, a1, d1, d2, ac, fv, fa, fd);
    @(negedge clk);
    in_valid = 0; fwd_valid = 0;
    chk({name, "_v"}, int'(out_valid), 1);
    chk({name, "_a"}, int'(alu_input1), ea);
    chk({name, "_b"}, int'(alu_input2), eb);
    chk({name, "_s"}, int'(out_src), int'(s));
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_a", int'(alu_input1), 0);
    rst = 0;
    @(negedge clk);
    one(2'b00, 16'h0000, 3'd1, 8'h12, 8'h34, 8'h00, 0, 3'd0, 8'h00, "rr", 'h12, 'h34);
    one(2'b11, 16'h1600, 3'd1, 8'h00, 8'h07, 8'h00, 0, 3'd0, 8'h00, "offs", 'h07, 'hF6);
    one(2'b01, 16'h0005, 3'd1, 8'h00, 8'h00, 8'h80, 0, 3'd0, 8'h00, "shamt", 'h80, 'h05);
    one(2'b10, 16'hA53C, 3'd3, 8'h11, 8'h00, 8'h00, 1, 3'd3, 8'h5A, "fwd", 'h5A, 'hA5);
    one(2'b10, 16'hA53C, 3'd3, 8'h11, 8'h00, 8'h00, 1, 3'd4, 8'h5A, "nofwd", 'h11, 'hA5);
    one(2'b00, 16'h0000, 3'd2, 8'h11, 8'h22, 8'h00, 1, 3'd2, 8'h99, "fwd2", 'h99, 'h99);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(2'b00, 16'h0, 3'd1, 8'(8'h40 + i), 8'(8'h50 + i), 8'h0, 0, 3'd0, 8'h0);
      @(negedge clk);
      if (i == 1) chk("full_ready", int'(in_ready), 0);
    end
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("hold_a", int'(alu_input1), 'h40);
    out_ready = 1;
    @(negedge clk);
    chk("drain_a", int'(alu_input1), 'h41);
    @(negedge clk);
    chk("drain_empty", int'(out_valid), 0);
    chk("drain_ready", int'(in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      set_req(2'b00, 16'h0, 3'd1, 8'(8'h60 + i), 8'(i), 8'h0, 0, 3'd0, 8'h0);
      @(negedge clk);
      chk("stream_a", int'(alu_input1), 'h60 + i);
      chk("stream_ready", int'(in_ready), 1);
    end
    in_valid = 0;
    @(negedge clk);
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      set_req(2'b11, 16'h1F00, 3'd1, 8'h0, 8'(8'h70 + i), 8'h0, 0, 3'd0, 8'h0);
      @(negedge clk);
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_a", int'(alu_input1), 0);
    chk("arst_b", int'(alu_input2), 0);
    chk("arst_src", int'(out_src), 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    chk("post_ready", int'(in_ready), 1);
    one(2'b11, 16'h0F00, 3'd1, 8'h00, 8'h3C, 8'h00, 0, 3'd0, 8'h00, "post", 'h3C, 'h0F);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
